// File: rtl/univ_shift_reg.sv
//------------------------------------------------------------------------------
// Module      : univ_shift_reg
// Description : WIDTH-bit universal register with hold, load, shifts, rotates,
//               synchronous clear and arithmetic shift right; serial I/O at
//               both ends and a zero flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module univ_shift_reg #(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_l,
    input  logic             si_r,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             zero
);

    localparam logic [WIDTH-1:0] c_RESET_Q   = RESET_VALUE[WIDTH-1:0];

    localparam logic [2:0] c_MODE_HOLD = 3'd0;
    localparam logic [2:0] c_MODE_LOAD = 3'd1;
    localparam logic [2:0] c_MODE_SHL  = 3'd2;
    localparam logic [2:0] c_MODE_SHR  = 3'd3;
    localparam logic [2:0] c_MODE_ROL  = 3'd4;
    localparam logic [2:0] c_MODE_ROR  = 3'd5;
    localparam logic [2:0] c_MODE_CLR  = 3'd6;
    localparam logic [2:0] c_MODE_ASR  = 3'd7;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_asr;

    // A single-bit register has no neighbours, so shifts take the serial
    // input directly and rotate/ASR degenerate to hold.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_shl = {r_q[WIDTH-2:0], si_r};
            assign w_shr = {si_l, r_q[WIDTH-1:1]};
            assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
            assign w_asr = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_shl = si_r;
            assign w_shr = si_l;
            assign w_rol = r_q;
            assign w_ror = r_q;
            assign w_asr = r_q;
        end
    endgenerate

    always_comb begin
        w_next = r_q;
        if (en) begin
            case (mode)
                c_MODE_HOLD: w_next = r_q;
                c_MODE_LOAD: w_next = d;
                c_MODE_SHL:  w_next = w_shl;
                c_MODE_SHR:  w_next = w_shr;
                c_MODE_ROL:  w_next = w_rol;
                c_MODE_ROR:  w_next = w_ror;
                c_MODE_CLR:  w_next = '0;
                c_MODE_ASR:  w_next = w_asr;
                default:     w_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= c_RESET_Q;
        end else begin
            r_q <= w_next;
        end
    end

    assign q    = r_q;
    assign so_l = r_q[WIDTH-1];
    assign so_r = r_q[0];
    assign zero = (r_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_univ_shift_reg
// Description : Scoreboard bench for univ_shift_reg (8-bit and 1-bit builds)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_univ_shift_reg;

    localparam logic [63:0] c_RV8 = 64'hA5;
    localparam logic [63:0] c_RV1 = 64'h2;   // only bit 0 (=0) is meaningful

    typedef struct {
        bit          sel;      // 0 = 8-bit DUT, 1 = 1-bit DUT
        logic [7:0]  q;
        string       name;
    } exp_t;

    logic       clk;
    logic       rst8, en8, sil8, sir8;
    logic [2:0] mode8;
    logic [7:0] d8, q8;
    logic       so_l8, so_r8, zero8;

    logic       rst1, en1, sil1, sir1;
    logic [2:0] mode1;
    logic [0:0] d1, q1;
    logic       so_l1, so_r1, zero1;

    exp_t       sb[$];
    event       mon_ev;
    int         n_vec;
    int         n_bad;
    logic [63:0] m8, m1;

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(c_RV8)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .d(d8),
        .si_l(sil8), .si_r(sir8), .q(q8), .so_l(so_l8), .so_r(so_r8), .zero(zero8)
    );

    univ_shift_reg #(.WIDTH(1), .RESET_VALUE(c_RV1)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .d(d1),
        .si_l(sil1), .si_r(sir1), .q(q1), .so_l(so_l1), .so_r(so_r1), .zero(zero1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, required finish");
        $fatal(1, "timeout");
    end

    // Next register value computed directly from the mode definitions.
    function automatic logic [63:0] ref_next(input int w, input logic [63:0] cur,
                                             input logic [2:0] mode, input logic [63:0] d,
                                             input bit sil, input bit sir);
        logic [63:0] mask, msb, lsb, n;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = (cur >> (w - 1)) & 64'd1;
        lsb  = cur & 64'd1;
        case (mode)
            3'd0:    n = cur;
            3'd1:    n = d;
            3'd2:    n = (cur << 1) | 64'(sir);
            3'd3:    n = (cur >> 1) | (64'(sil) << (w - 1));
            3'd4:    n = (cur << 1) | msb;
            3'd5:    n = (cur >> 1) | (lsb << (w - 1));
            3'd6:    n = 64'd0;
            default: n = (cur >> 1) | (msb << (w - 1));
        endcase
        return n & mask;
    endfunction

    function automatic void push(input bit sel, input logic [63:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.q    = v[7:0];
        e.name = name;
        sb.push_back(e);
    endfunction

    // Monitor: each notification pops every pending expectation and compares.
    initial begin
        exp_t e;
        logic [7:0] aq;
        logic       al, ar, az, el, er, ez;
        forever begin
            @(mon_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == 1'b0) begin
                    aq = q8; al = so_l8; ar = so_r8; az = zero8;
                    el = e.q[7];
                end else begin
                    aq = {7'd0, q1}; al = so_l1; ar = so_r1; az = zero1;
                    el = e.q[0];
                end
                er = e.q[0];
                ez = (e.q == 8'd0);
                n_vec++;
                if (aq !== e.q || al !== el || ar !== er || az !== ez) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got q=%h so_l=%b so_r=%b zero=%b, required q=%h so_l=%b so_r=%b zero=%b",
                             e.name, e.sel ? 1 : 8, aq, al, ar, az, e.q, el, er, ez);
                end
            end
        end
    end

    task automatic step8(input bit en, input logic [2:0] mode, input logic [7:0] d,
                         input bit sil, input bit sir, input string name);
        @(negedge clk);
        en8 = en; mode8 = mode; d8 = d; sil8 = sil; sir8 = sir;
        if (en) m8 = ref_next(8, m8, mode, {56'd0, d}, sil, sir);
        push(1'b0, m8, name);
        @(posedge clk);
        -> mon_ev;
        #2 en8 = 1'b0;
    endtask

    task automatic step1(input bit en, input logic [2:0] mode, input bit d,
                         input bit sil, input bit sir, input string name);
        @(negedge clk);
        en1 = en; mode1 = mode; d1 = d; sil1 = sil; sir1 = sir;
        if (en) m1 = ref_next(1, m1, mode, {63'd0, d}, sil, sir);
        push(1'b1, m1, name);
        @(posedge clk);
        -> mon_ev;
        #2 en1 = 1'b0;
    endtask

    // Reset asserted mid-cycle; the result must appear before the next edge.
    task automatic rst_pulse8(input string name);
        @(posedge clk);
        #3 rst8 = 1'b1;
        m8 = c_RV8 & 64'hFF;
        push(1'b0, m8, name);
        -> mon_ev;
        @(negedge clk);
        rst8 = 1'b0;
    endtask

    initial begin
        logic [7:0] so_seq;
        n_vec = 0; n_bad = 0;
        rst8 = 1'b1; en8 = 1'b0; mode8 = 3'd0; d8 = 8'd0; sil8 = 1'b0; sir8 = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = 3'd0; d1 = 1'b0; sil1 = 1'b0; sir1 = 1'b0;
        m8 = c_RV8 & 64'hFF;
        m1 = c_RV1 & 64'h1;
        #3;
        push(1'b0, m8, "reset8");
        push(1'b1, m1, "reset1");
        -> mon_ev;
        @(negedge clk);
        rst8 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < 3; i++) step8(1, 3'd0, 8'hFF, 1, 1, "hold_after_rst");
        rst_pulse8("async_rst_midcycle");

        step8(1, 3'd1, 8'h3C, 0, 0, "load_3c");
        step8(0, 3'd6, 8'h00, 0, 0, "en0_clr");
        step8(1, 3'd6, 8'h00, 0, 0, "clr");

        step8(1, 3'd1, 8'h81, 0, 0, "load_81");
        step8(1, 3'd2, 8'h00, 0, 1, "shl_sir1");
        step8(1, 3'd3, 8'h00, 0, 0, "shr_sil0");
        step8(1, 3'd3, 8'h00, 1, 0, "shr_sil1");
        step8(1, 3'd1, 8'hF0, 0, 0, "load_f0");
        step8(1, 3'd7, 8'h00, 0, 0, "asr_neg");
        step8(1, 3'd1, 8'h70, 0, 0, "load_70");
        step8(1, 3'd7, 8'h00, 1, 1, "asr_pos");

        step8(1, 3'd1, 8'h81, 0, 0, "load_81b");
        step8(1, 3'd4, 8'h00, 0, 0, "rol");
        step8(1, 3'd5, 8'h00, 0, 0, "ror");
        for (int i = 0; i < 8; i++) step8(1, 3'd4, 8'h00, 1, 1, "rol_x8");

        step8(1, 3'd1, 8'hB6, 0, 0, "load_b6");
        so_seq = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            so_seq[i] = so_r8;
            step8(1, 3'd3, 8'h00, m8[0], 0, "serial_rt");
        end
        n_vec++;
        if (so_seq !== 8'hB6) begin
            n_bad++;
            $display("FAIL serial_so_r_seq: got %b (bit0 first), required %b", so_seq, 8'hB6);
        end

        step8(1, 3'd2, 8'h00, 0, 1, "shl_pre_rst");
        step8(1, 3'd2, 8'h00, 0, 0, "shl_pre_rst");
        rst_pulse8("rst_mid_op");
        step8(1, 3'd2, 8'h00, 0, 0, "shl_after_rst");

        step1(1, 3'd2, 0, 0, 1, "w1_shl_sir1");
        step1(1, 3'd4, 0, 0, 0, "w1_rol");
        step1(1, 3'd5, 0, 1, 0, "w1_ror");
        step1(1, 3'd7, 0, 0, 0, "w1_asr");
        step1(1, 3'd6, 0, 1, 1, "w1_clr");
        step1(1, 3'd3, 0, 1, 0, "w1_shr_sil1");
        step1(1, 3'd1, 0, 1, 1, "w1_load0");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) rst_pulse8("rand_rst8");
            step8($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom), 1'($urandom), "rand8");
            step1($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 1'($urandom), "rand1");
        end

        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal register: the next generation of the team's single-bit master-slave DFF.
- Generalised to a WIDTH-bit, edge-triggered register with asynchronous reset, a programmable reset value and an enable.
- Adds eight operating modes: hold, parallel load, logical shifts, rotates, arithmetic shift right and synchronous clear, with serial in/out on both ends.
- Used as a building block for serial links, counters and datapath test circuits.

Parameters:
- WIDTH, 8, register width in bits; legal range 1..64.
- RESET_VALUE, 0, value loaded into q by reset; WIDTH bits, upper bits ignored.

Ports:
- clk  input  1  clock; all state changes on rising edge except reset.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; 0 = hold regardless of mode.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- si_l  input  1  serial input entering at MSB (used by shift right).
- si_r  input  1  serial input entering at LSB (used by shift left).
- q  output  WIDTH  register contents.
- so_l  output  1  q[WIDTH-1], combinational from q.
- so_r  output  1  q[0], combinational from q.
- zero  output  1  1 when q == 0, combinational from q.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, q = RESET_VALUE immediately, independent of clk.
  - so_l, so_r and zero follow q.
  - Release of rst takes effect at the next rising clk edge after deassertion.
  - Reset mid-operation discards the in-flight shift.
- en=0 at a rising edge: q unchanged for every mode.
- en=1 at a rising edge, by mode:
  - 0 HOLD: q unchanged.
  - 1 LOAD: q <= d.
  - 2 SHL: q <= {q[WIDTH-2:0], si_r}.
  - 3 SHR: q <= {si_l, q[WIDTH-1:1]}.
  - 4 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 5 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 6 CLR: q <= 0. This is a synchronous clear, distinct from RESET_VALUE.
  - 7 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]} (sign bit replicated).
- Latency: one cycle; q reflects the operation after the edge, and no combinational path exists from inputs to q.
- WIDTH=1 degenerate case:
  - SHL: q <= si_r.
  - SHR: q <= si_l.
  - ROL, ROR, ASR: q unchanged.
  - RTL handles this without out-of-range slices.
- Shift-out capture: bits shifted out are lost. Downstream logic samples so_l/so_r before the edge.
- Unknown/X on mode with en=1: no requirement on q. Bench does not drive X.
- No state beyond q. Flags are pure functions of q.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5. Assert rst asynchronously mid-cycle -> q=8'hA5 before the next edge; zero=0. Deassert, mode=HOLD 3 cycles -> q stays 8'hA5.
- Load/clear: mode=LOAD, d=8'h3C, en=1, one edge -> q=8'h3C. Then en=0, mode=CLR -> q=8'h3C. Then en=1, mode=CLR -> q=8'h00, zero=1.
- Shifts:
  - From q=8'h81: SHL with si_r=1 -> 8'h03. SHR with si_l=0 -> 8'h01. SHR with si_l=1 -> 8'h80.
  - From q=8'hF0: ASR -> 8'hF8.
  - From q=8'h70: ASR -> 8'h38.
- Rotates: from q=8'h81, ROL -> 8'h03, ROR -> 8'h81; 8 consecutive ROLs return q=8'h81.
- Serial round-trip: load 8'hB6, then 8 SHR edges with si_l tied to so_r -> q=8'hB6, and so_r sequence = 0,1,1,0,1,1,0,1.
- Mid-operation reset and WIDTH=1:
  - rst pulse between shift edges -> q=RESET_VALUE; the next SHL shifts from RESET_VALUE.
  - WIDTH=1 instance: SHL with si_r=1 -> q=1; ROL -> q=1; CLR -> q=0.
